// File: rtl/pixel_serializer.sv
// pixel_serializer: takes 256-bit burst words holding PPB packed pixels and
// replays them as a LANES-wide pixel stream with frame markers and coordinates.
// Two word buffers are used in ping-pong fashion, so one can refill while the
// other streams. The output runs at one beat per cycle while data is available.
module pixel_serializer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LANES       = 1,
    parameter int IN_ROWS     = 20,
    parameter int IN_COLS     = 20
) (
    input  logic                             clk,
    input  logic                             s_axis_resetn,
    input  logic                             ap_start,
    output logic                             ap_ready,
    output logic                             ap_idle,
    output logic                             ap_done,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic [255:0]                     s_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [LANES*PIXEL_WIDTH-1:0]     m_axis_tdata,
    output logic                             m_axis_tuser,
    output logic                             m_axis_tlast,
    output logic [$clog2(IN_COLS)-1:0]       cnt_col,
    output logic [$clog2(IN_ROWS)-1:0]       cnt_row
);

    localparam int PPB    = 256 / PIXEL_WIDTH;
    localparam int GROUPS = PPB / LANES;
    localparam int TOTAL  = IN_ROWS * IN_COLS;
    localparam int WORDS  = TOTAL / PPB;
    localparam int BEATS  = TOTAL / LANES;
    localparam int BEAT_W = LANES * PIXEL_WIDTH;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int WCNT_W = $clog2(WORDS + 1);
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int COL_W  = $clog2(IN_COLS);
    localparam int ROW_W  = $clog2(IN_ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [255:0]        entry_data [2];
    logic [1:0]          entry_full;
    logic                wr_ptr;
    logic                rd_ptr;
    logic [GRP_W-1:0]    grp;
    logic [WCNT_W-1:0]   fetched;
    logic [BCNT_W-1:0]   beat;
    logic                stream_valid;
    logic                out_hs;
    logic                in_hs;
    logic                last_grp;
    logic                free_entry;

    // Frame control state register.
    always_ff @(posedge clk) begin
        if (!s_axis_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; the final word fetch moves RUN to DRAIN.
    always_comb begin
        state_next = state;
        ap_idle    = 1'b0;
        ap_ready   = 1'b0;
        ap_done    = 1'b0;
        case (state)
            IDLE: begin
                ap_idle  = 1'b1;
                ap_ready = 1'b1;
                if (ap_start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (in_hs && fetched == WCNT_W'(WORDS - 1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs && m_axis_tlast) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ap_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stream-side handshakes; an entry freed by its last group may be refilled in the same cycle.
    always_comb begin
        stream_valid  = (state == RUN || state == DRAIN) && entry_full[rd_ptr];
        out_hs        = stream_valid && m_axis_tready;
        last_grp      = (grp == GRP_W'(GROUPS - 1));
        free_entry    = out_hs && last_grp;
        s_axis_tready = (state == RUN) && (fetched < WCNT_W'(WORDS)) &&
                        (!entry_full[wr_ptr] || (wr_ptr == rd_ptr && free_entry));
        in_hs         = s_axis_tvalid && s_axis_tready;
        m_axis_tvalid = stream_valid;
        m_axis_tdata  = '0;
        m_axis_tuser  = 1'b0;
        m_axis_tlast  = 1'b0;
        if (stream_valid) begin
            m_axis_tdata = entry_data[rd_ptr][grp*BEAT_W +: BEAT_W];
            m_axis_tuser = (beat == '0);
            m_axis_tlast = (beat == BCNT_W'(BEATS - 1));
        end
    end

    // Word storage; contents need no reset because the output is gated by the full flags.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            entry_data[wr_ptr] <= s_axis_tdata;
        end
    end

    // Buffer bookkeeping and frame counters, all cleared on reset and when a frame completes.
    always_ff @(posedge clk) begin
        if (!s_axis_resetn || state == DONE) begin
            entry_full <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            grp        <= '0;
            fetched    <= '0;
            beat       <= '0;
            cnt_col    <= '0;
            cnt_row    <= '0;
        end else begin
            if (in_hs) begin
                wr_ptr  <= ~wr_ptr;
                fetched <= fetched + 1'b1;
            end
            if (out_hs) begin
                beat <= beat + 1'b1;
                if (last_grp) begin
                    grp    <= '0;
                    rd_ptr <= ~rd_ptr;
                end else begin
                    grp <= grp + 1'b1;
                end
                if (cnt_col == COL_W'(IN_COLS - LANES)) begin
                    cnt_col <= '0;
                    cnt_row <= (cnt_row == ROW_W'(IN_ROWS - 1)) ? '0 : cnt_row + 1'b1;
                end else begin
                    cnt_col <= cnt_col + COL_W'(LANES);
                end
            end
            if (free_entry) begin
                entry_full[rd_ptr] <= 1'b0;
            end
            if (in_hs) begin
                entry_full[wr_ptr] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_serializer.sv
// tb_pixel_serializer: drives random and ramp frames into two configurations
// (8-bit single lane 32x2, 16-bit four lane 8x4) and compares every output beat
// against the pixel/coordinate sequence the frame should produce.
module tb_pixel_serializer;

    localparam int A_L = 1, A_COLS = 32, A_TOTAL = 64, A_PPB = 32, A_WORDS = 2, A_BEATS = 64;
    localparam int B_L = 4, B_COLS = 8, B_TOTAL = 32, B_PPB = 16, B_WORDS = 2, B_BEATS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn_a = 1'b0, start_a = 1'b0, s_valid_a = 1'b0, m_ready_a = 1'b0;
    logic [255:0] s_data_a = '0;
    logic         ready_a, idle_a, done_a, s_ready_a, m_valid_a, user_a, last_a;
    logic [7:0]   m_data_a;
    logic [4:0]   col_a;
    logic [0:0]   row_a;

    logic         rstn_b = 1'b0, start_b = 1'b0, s_valid_b = 1'b0, m_ready_b = 1'b0;
    logic [255:0] s_data_b = '0;
    logic         ready_b, idle_b, done_b, s_ready_b, m_valid_b, user_b, last_b;
    logic [63:0]  m_data_b;
    logic [2:0]   col_b;
    logic [1:0]   row_b;

    pixel_serializer #(.PIXEL_WIDTH(8), .LANES(1), .IN_ROWS(2), .IN_COLS(32)) dut_a (
        .clk(clk), .s_axis_resetn(rstn_a), .ap_start(start_a), .ap_ready(ready_a),
        .ap_idle(idle_a), .ap_done(done_a), .s_axis_tvalid(s_valid_a), .s_axis_tready(s_ready_a),
        .s_axis_tdata(s_data_a), .m_axis_tvalid(m_valid_a), .m_axis_tready(m_ready_a),
        .m_axis_tdata(m_data_a), .m_axis_tuser(user_a), .m_axis_tlast(last_a),
        .cnt_col(col_a), .cnt_row(row_a)
    );

    pixel_serializer #(.PIXEL_WIDTH(16), .LANES(4), .IN_ROWS(4), .IN_COLS(8)) dut_b (
        .clk(clk), .s_axis_resetn(rstn_b), .ap_start(start_b), .ap_ready(ready_b),
        .ap_idle(idle_b), .ap_done(done_b), .s_axis_tvalid(s_valid_b), .s_axis_tready(s_ready_b),
        .s_axis_tdata(s_data_b), .m_axis_tvalid(m_valid_b), .m_axis_tready(m_ready_b),
        .m_axis_tdata(m_data_b), .m_axis_tuser(user_b), .m_axis_tlast(last_b),
        .cnt_col(col_b), .cnt_row(row_b)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  frame_a [A_TOTAL];
    logic [15:0] frame_b [B_TOTAL];

    int   src_a, cyc_a, gaps_a, stall_chg_a, done_cnt_a, done_cyc_a, last_cyc_a;
    bit   last_seen_a, prev_stall_a;
    logic [7:0]  prev_data_a;
    logic        prev_user_a, prev_last_a;
    logic [15:0] obs_a [$];
    int          beat_cyc_a [$];
    int          acc_cyc_a [$];

    int          src_b, done_cnt_b;
    logic [70:0] obs_b [$];

    // Input word w packs pixels w*PPB.. with pixel p at bits [p*PW +: PW]; past the frame it is filler.
    function automatic logic [255:0] word_a(input int w);
        logic [255:0] d;
        d = {8{32'hDEADBEEF}};
        if (w < A_WORDS) begin
            for (int p = 0; p < A_PPB; p++) d[p*8 +: 8] = frame_a[w*A_PPB + p];
        end
        return d;
    endfunction

    function automatic logic [255:0] word_b(input int w);
        logic [255:0] d;
        d = {8{32'hCAFEF00D}};
        if (w < B_WORDS) begin
            for (int p = 0; p < B_PPB; p++) d[p*16 +: 16] = frame_b[w*B_PPB + p];
        end
        return d;
    endfunction

    // One clock of DUT A: drive at the falling edge, observe 3 time units later.
    task automatic step_a(input bit start, input bit offer, input bit mready, input bit rst);
        @(negedge clk);
        rstn_a    = !rst;
        start_a   = start;
        s_valid_a = offer;
        s_data_a  = word_a(src_a);
        m_ready_a = mready;
        #3;
        cyc_a++;
        if (s_valid_a && s_ready_a === 1'b1) begin
            acc_cyc_a.push_back(cyc_a);
            src_a++;
        end
        if (prev_stall_a && !(m_valid_a === 1'b1 && m_data_a === prev_data_a &&
                              user_a === prev_user_a && last_a === prev_last_a))
            stall_chg_a++;
        if (obs_a.size() > 0 && !last_seen_a && m_valid_a !== 1'b1) gaps_a++;
        if (m_valid_a === 1'b1 && m_ready_a) begin
            obs_a.push_back({m_data_a, user_a, last_a, col_a, row_a});
            beat_cyc_a.push_back(cyc_a);
            if (last_a === 1'b1) begin
                last_seen_a = 1'b1;
                last_cyc_a  = cyc_a;
            end
        end
        if (done_a === 1'b1) begin
            done_cnt_a++;
            done_cyc_a = cyc_a;
        end
        prev_stall_a = (m_valid_a === 1'b1) && !m_ready_a;
        prev_data_a  = m_data_a;
        prev_user_a  = user_a;
        prev_last_a  = last_a;
    endtask

    task automatic step_b(input bit start, input bit offer, input bit mready, input bit rst);
        @(negedge clk);
        rstn_b    = !rst;
        start_b   = start;
        s_valid_b = offer;
        s_data_b  = word_b(src_b);
        m_ready_b = mready;
        #3;
        if (s_valid_b && s_ready_b === 1'b1) src_b++;
        if (m_valid_b === 1'b1 && m_ready_b) obs_b.push_back({m_data_b, user_b, last_b, col_b, row_b});
        if (done_b === 1'b1) done_cnt_b++;
    endtask

    task automatic clear_a();
        obs_a.delete();
        beat_cyc_a.delete();
        acc_cyc_a.delete();
        src_a = 0; cyc_a = 0; gaps_a = 0; stall_chg_a = 0; done_cnt_a = 0;
        done_cyc_a = -1; last_cyc_a = -1; last_seen_a = 1'b0; prev_stall_a = 1'b0;
    endtask

    task automatic fill_a(input bit ramp);
        for (int i = 0; i < A_TOTAL; i++) frame_a[i] = ramp ? 8'(i) : 8'($urandom);
    endtask

    // Start a frame on A with input valid held high and run until ap_done or the budget expires.
    task automatic run_frame_a(input int stall_pct, input bit pulse_mid, output bit timeout);
        int n;
        step_a(1'b1, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (done_cnt_a == 0 && n < 3000) begin
            step_a(pulse_mid && (n == 5 || n == 20), 1'b1, ($urandom_range(99) >= stall_pct), 1'b0);
            n++;
        end
        timeout = (done_cnt_a == 0);
    endtask

    task automatic test_reset();
        step_a(1'b0, 1'b0, 1'b1, 1'b1);
        step_a(1'b0, 1'b0, 1'b1, 1'b1);
        step_b(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (idle_a !== 1'b1) begin failures++; $display("[TB] FAIL reset_idle got=%b exp=1", idle_a); end
        checks++; if (ready_a !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", ready_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done_a); end
        checks++; if (s_ready_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_s_ready got=%b exp=0", s_ready_a); end
        checks++; if (m_valid_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_valid got=%b exp=0", m_valid_a); end
        checks++; if (user_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_tuser got=%b exp=0", user_a); end
        checks++; if (last_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_tlast got=%b exp=0", last_a); end
        checks++; if (m_data_a !== 8'h00) begin failures++; $display("[TB] FAIL reset_tdata got=%h exp=00", m_data_a); end
        checks++; if (col_a !== 5'd0) begin failures++; $display("[TB] FAIL reset_col got=%0d exp=0", col_a); end
        checks++; if (row_a !== 1'd0) begin failures++; $display("[TB] FAIL reset_row got=%0d exp=0", row_a); end
        checks++; if (idle_b !== 1'b1 || m_valid_b !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_b got=idle%b/valid%b exp=idle1/valid0", idle_b, m_valid_b);
        end
        step_a(1'b0, 1'b0, 1'b1, 1'b0);
        step_b(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_ramp();
        bit to;
        logic [15:0] exp;
        clear_a();
        fill_a(1'b1);
        run_frame_a(0, 1'b0, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL ramp_timeout got=no_done exp=done"); end
        checks++; if (obs_a.size() !== A_BEATS) begin failures++; $display("[TB] FAIL ramp_count got=%0d exp=%0d", obs_a.size(), A_BEATS); end
        for (int b = 0; b < A_BEATS && b < obs_a.size(); b++) begin
            exp = {frame_a[b*A_L], (b == 0), (b == A_BEATS-1), 5'((b*A_L) % A_COLS), 1'((b*A_L) / A_COLS)};
            checks++; if (obs_a[b] !== exp) begin failures++; $display("[TB] FAIL ramp_beat%0d got=%h exp=%h", b, obs_a[b], exp); end
        end
        checks++; if (done_cyc_a !== last_cyc_a + 1) begin
            failures++; $display("[TB] FAIL ramp_done_cycle got=%0d exp=%0d", done_cyc_a, last_cyc_a + 1);
        end
        step_a(1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (idle_a !== 1'b1) begin failures++; $display("[TB] FAIL ramp_idle_after got=%b exp=1", idle_a); end
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [15:0] exp;
        clear_a();
        fill_a(1'b0);
        run_frame_a(0, 1'b0, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL b2b_timeout got=no_done exp=done"); end
        checks++; if (gaps_a !== 0) begin failures++; $display("[TB] FAIL b2b_gaps got=%0d exp=0", gaps_a); end
        checks++; if (acc_cyc_a.size() !== A_WORDS) begin
            failures++; $display("[TB] FAIL b2b_words got=%0d exp=%0d", acc_cyc_a.size(), A_WORDS);
        end else if (beat_cyc_a.size() >= A_PPB) begin
            checks++; if (beat_cyc_a[0] !== acc_cyc_a[0] + 1) begin
                failures++; $display("[TB] FAIL b2b_latency got=%0d exp=%0d", beat_cyc_a[0], acc_cyc_a[0] + 1);
            end
            checks++; if (!(acc_cyc_a[1] < beat_cyc_a[A_PPB-1])) begin
                failures++; $display("[TB] FAIL b2b_overlap got=%0d exp=<%0d", acc_cyc_a[1], beat_cyc_a[A_PPB-1]);
            end
        end
        for (int b = 0; b < A_BEATS && b < obs_a.size(); b++) begin
            exp = {frame_a[b*A_L], (b == 0), (b == A_BEATS-1), 5'((b*A_L) % A_COLS), 1'((b*A_L) / A_COLS)};
            checks++; if (obs_a[b] !== exp) begin failures++; $display("[TB] FAIL b2b_beat%0d got=%h exp=%h", b, obs_a[b], exp); end
        end
    endtask

    task automatic test_stall();
        bit to;
        logic [15:0] exp;
        clear_a();
        fill_a(1'b0);
        run_frame_a(50, 1'b0, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL stall_timeout got=no_done exp=done"); end
        checks++; if (stall_chg_a !== 0) begin failures++; $display("[TB] FAIL stall_stable got=%0d exp=0", stall_chg_a); end
        checks++; if (obs_a.size() !== A_BEATS) begin failures++; $display("[TB] FAIL stall_count got=%0d exp=%0d", obs_a.size(), A_BEATS); end
        for (int b = 0; b < A_BEATS && b < obs_a.size(); b++) begin
            exp = {frame_a[b*A_L], (b == 0), (b == A_BEATS-1), 5'((b*A_L) % A_COLS), 1'((b*A_L) / A_COLS)};
            checks++; if (obs_a[b] !== exp) begin failures++; $display("[TB] FAIL stall_beat%0d got=%h exp=%h", b, obs_a[b], exp); end
        end
    endtask

    task automatic test_midframe_reset();
        bit to;
        int n;
        logic [15:0] exp;
        clear_a();
        fill_a(1'b0);
        step_a(1'b1, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (obs_a.size() < 10 && n < 500) begin
            step_a(1'b0, 1'b1, 1'b1, 1'b0);
            n++;
        end
        checks++; if (obs_a.size() !== 10) begin failures++; $display("[TB] FAIL mrst_reach10 got=%0d exp=10", obs_a.size()); end
        step_a(1'b0, 1'b0, 1'b1, 1'b1);
        clear_a();
        step_a(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (m_valid_a !== 1'b0 || idle_a !== 1'b1 || col_a !== 5'd0) begin
            failures++; $display("[TB] FAIL mrst_after got=valid%b/idle%b/col%0d exp=valid0/idle1/col0", m_valid_a, idle_a, col_a);
        end
        clear_a();
        fill_a(1'b0);
        run_frame_a(0, 1'b0, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL mrst_timeout got=no_done exp=done"); end
        checks++; if (obs_a.size() !== A_BEATS) begin failures++; $display("[TB] FAIL mrst_count got=%0d exp=%0d", obs_a.size(), A_BEATS); end
        for (int b = 0; b < A_BEATS && b < obs_a.size(); b++) begin
            exp = {frame_a[b*A_L], (b == 0), (b == A_BEATS-1), 5'((b*A_L) % A_COLS), 1'((b*A_L) / A_COLS)};
            checks++; if (obs_a[b] !== exp) begin failures++; $display("[TB] FAIL mrst_beat%0d got=%h exp=%h", b, obs_a[b], exp); end
        end
    endtask

    task automatic test_start_ignored();
        bit to;
        logic [15:0] exp;
        clear_a();
        fill_a(1'b0);
        run_frame_a(0, 1'b1, to);
        for (int i = 0; i < 30; i++) step_a(1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (to) begin failures++; $display("[TB] FAIL start_timeout got=no_done exp=done"); end
        checks++; if (done_cnt_a !== 1) begin failures++; $display("[TB] FAIL start_done_count got=%0d exp=1", done_cnt_a); end
        checks++; if (acc_cyc_a.size() !== A_WORDS) begin
            failures++; $display("[TB] FAIL start_extra_words got=%0d exp=%0d", acc_cyc_a.size(), A_WORDS);
        end
        checks++; if (obs_a.size() !== A_BEATS) begin failures++; $display("[TB] FAIL start_count got=%0d exp=%0d", obs_a.size(), A_BEATS); end
        for (int b = 0; b < A_BEATS && b < obs_a.size(); b++) begin
            exp = {frame_a[b*A_L], (b == 0), (b == A_BEATS-1), 5'((b*A_L) % A_COLS), 1'((b*A_L) / A_COLS)};
            checks++; if (obs_a[b] !== exp) begin failures++; $display("[TB] FAIL start_beat%0d got=%h exp=%h", b, obs_a[b], exp); end
        end
    endtask

    task automatic test_wide();
        int n;
        logic [63:0] d;
        logic [70:0] exp;
        for (int i = 0; i < B_TOTAL; i++) frame_b[i] = 16'($urandom);
        obs_b.delete();
        src_b = 0;
        done_cnt_b = 0;
        step_b(1'b1, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (done_cnt_b == 0 && n < 500) begin
            step_b(1'b0, 1'b1, 1'b1, 1'b0);
            n++;
        end
        checks++; if (done_cnt_b !== 1) begin failures++; $display("[TB] FAIL wide_done got=%0d exp=1", done_cnt_b); end
        checks++; if (obs_b.size() !== B_BEATS) begin failures++; $display("[TB] FAIL wide_count got=%0d exp=%0d", obs_b.size(), B_BEATS); end
        for (int b = 0; b < B_BEATS && b < obs_b.size(); b++) begin
            for (int k = 0; k < B_L; k++) d[k*16 +: 16] = frame_b[b*B_L + k];
            exp = {d, (b == 0), (b == B_BEATS-1), 3'((b*B_L) % B_COLS), 2'((b*B_L) / B_COLS)};
            checks++; if (obs_b[b] !== exp) begin failures++; $display("[TB] FAIL wide_beat%0d got=%h exp=%h", b, obs_b[b], exp); end
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_stall();
        test_midframe_reset();
        test_start_ignored();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_serializer.md
PIXEL_SERIALIZER -- requirements
Module: pixel_serializer

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, meaning bits per pixel; legal values 8 or 16 only.
REQ-002 SHALL have parameter LANES, default 1, meaning pixels per output beat; legal values 1, 2 or 4.
REQ-003 SHALL have parameter IN_ROWS, default 20, meaning frame height in pixels.
REQ-004 SHALL have parameter IN_COLS, default 20, meaning frame width in pixels; must be a multiple of LANES.
REQ-005 SHALL derive PPB = 256/PIXEL_WIDTH, GROUPS = PPB/LANES and TOTAL = IN_ROWS*IN_COLS; TOTAL must be a multiple of PPB.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port s_axis_resetn, input, 1, reset, synchronous, active-low.
REQ-008 SHALL have ports ap_start (in, 1), ap_ready (out, 1), ap_idle (out, 1) and ap_done (out, 1), the frame control handshake.
REQ-009 SHALL have ports s_axis_tvalid (in, 1), s_axis_tready (out, 1) and s_axis_tdata (in, 256), the input burst stream.
REQ-010 SHALL have ports m_axis_tvalid (out, 1), m_axis_tready (in, 1) and m_axis_tdata (out, LANES*PIXEL_WIDTH), the output pixel stream.
REQ-011 SHALL have ports m_axis_tuser (out, 1), asserted on the first beat of a frame, and m_axis_tlast (out, 1), asserted on the last beat.
REQ-012 SHALL have ports cnt_col (out, clog2(IN_COLS)) and cnt_row (out, clog2(IN_ROWS)), the coordinates of lane 0 of the current output beat.

Function
REQ-013 SHALL implement a state machine with states IDLE, RUN, DRAIN and DONE.
REQ-014 In IDLE: ap_idle=1, ap_ready=1, s_axis_tready=0, m_axis_tvalid=0; ap_start=1 -> RUN on the next cycle.
REQ-015 In RUN: ap_idle=0, ap_ready=0; input beats are accepted while words remain to be fetched for the frame (TOTAL/PPB words).
REQ-016 SHALL hold a two-entry buffer (ping-pong); s_axis_tready=1 whenever an entry is free and fetched words < TOTAL/PPB.
REQ-017 An input handshake in cycle t into an empty block SHALL produce m_axis_tvalid=1 in cycle t+1.
REQ-018 Output beat g of a word SHALL carry pixels g*LANES..g*LANES+LANES-1; the pixel at index p occupies s_axis_tdata[(p+1)*PIXEL_WIDTH-1 : p*PIXEL_WIDTH]; lane k occupies m_axis_tdata[(k+1)*PIXEL_WIDTH-1 : k*PIXEL_WIDTH].
REQ-019 The output handshake on the last group of one entry SHALL switch to the other entry in the same cycle if it is full: no bubble, sustained 1 beat/cycle.
REQ-020 A simultaneous input handshake and handshake on the last group SHALL be legal; the freed entry is refilled in that cycle.
REQ-021 m_axis_tdata, tuser and tlast SHALL be held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-022 On each output handshake, cnt_col SHALL advance by LANES, wrapping to 0 after IN_COLS-LANES; cnt_row SHALL advance when cnt_col wraps.
REQ-023 The frame beat counter SHALL count TOTAL/LANES beats; tuser=1 at count 0, tlast=1 at count TOTAL/LANES-1.
REQ-024 After the fetch limit is reached, the block SHALL be in DRAIN with s_axis_tready=0, and SHALL enter DONE on the tlast handshake.
REQ-025 DONE SHALL last one cycle with ap_done=1, then go to IDLE, with counters cleared to 0.
REQ-026 ap_start SHALL be ignored outside IDLE; extra input beats beyond a frame SHALL NOT be accepted.

Reset
REQ-027 With s_axis_resetn=0 at a clock edge, the block SHALL go to IDLE, empty both entries and clear all counters.
REQ-028 Reset values: ap_idle=1, ap_ready=1; ap_done, s_axis_tready, m_axis_tvalid, tuser, tlast, m_axis_tdata, cnt_col and cnt_row all 0.
REQ-029 Reset mid-frame SHALL discard buffered pixels; the next frame SHALL start with tuser and coordinates (0,0).

Verification
REQ-030 PW=8, LANES=1, 32x2 frame, ramp data 0..63, tready=1 -> 64 beats with data equal to the index, tuser on beat 0, tlast on beat 63, ap_done one cycle later.
REQ-031 Same frame with s_axis_tvalid held 1 -> no m_axis_tvalid gap after the first beat; input beat 2 accepted while beat 1 streams.
REQ-032 PW=16, LANES=4, 8x4 frame -> 8 beats; beat 0 = pixels {3,2,1,0}; cnt_col sequence 0,4,0,4,...
REQ-033 Random m_axis_tready (50%) -> data stable under stall; sequence identical to the no-stall run.
REQ-034 s_axis_resetn=0 at beat 10 of a frame, then a new ap_start -> first beat is pixel 0 of the new frame, (0,0), tuser=1.
REQ-035 ap_start pulsed during RUN -> no effect; exactly one ap_done per frame.
